// File: rtl/muldiv_pkg.sv
// muldiv_pkg: RV32M funct3 encodings and FSM states shared by the multiply/divide unit
package muldiv_pkg;
    typedef enum logic [2:0] {
        OP_MUL    = 3'b000,
        OP_MULH   = 3'b001,
        OP_MULHSU = 3'b010,
        OP_MULHU  = 3'b011,
        OP_DIV    = 3'b100,
        OP_DIVU   = 3'b101,
        OP_REM    = 3'b110,
        OP_REMU   = 3'b111
    } op_e;
    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_FIX  = 2'd2,
        S_DONE = 2'd3
    } state_e;
endpackage

// File: rtl/muldiv_unit.sv
// muldiv_unit: iterative RV32M multiply/divide, fixed 33-edge latency from start to done
module muldiv_unit
    import muldiv_pkg::*;
#(
    parameter int SIZE = 32
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            start,
    input  logic [2:0]      funct3,
    input  logic [SIZE-1:0] operand_1,
    input  logic [SIZE-1:0] operand_2,
    output logic            busy,
    output logic            done,
    output logic [SIZE-1:0] result
);
    localparam int CW = $clog2(SIZE);
    state_e            state;
    op_e               op;
    logic [SIZE-1:0]   a, b;
    logic [2*SIZE-1:0] acc;
    logic [SIZE:0]     rem;
    logic [CW-1:0]     cnt;
    logic              neg_p, neg_r;
    op_e               op_in;
    logic              sa, sb;
    logic [SIZE-1:0]   abs_a, abs_b;
    logic [SIZE:0]     msum, shifted;
    logic              ge;
    logic [2*SIZE-1:0] prod;
    logic [SIZE-1:0]   quot, rmd, res;
    assign op_in = op_e'(funct3);
    assign sa    = operand_1[SIZE-1] & (op_in inside {OP_MULH, OP_MULHSU, OP_DIV, OP_REM});
    assign sb    = operand_2[SIZE-1] & (op_in inside {OP_MULH, OP_DIV, OP_REM});
    assign abs_a = sa ? -operand_1 : operand_1;
    assign abs_b = sb ? -operand_2 : operand_2;
    // Multiply keeps the multiplier in acc's low half; divide keeps dividend/quotient there
    assign msum    = {1'b0, acc[2*SIZE-1:SIZE]} + (acc[0] ? {1'b0, a} : '0);
    assign shifted = {rem[SIZE-1:0], acc[SIZE-1]};
    assign ge      = shifted >= {1'b0, b};
    // A zero divisor already yields all-ones quotient and |dividend| remainder; only suppress negation
    assign prod = neg_p ? -acc : acc;
    assign quot = (neg_p && |b) ? -acc[SIZE-1:0] : acc[SIZE-1:0];
    assign rmd  = neg_r ? -rem[SIZE-1:0] : rem[SIZE-1:0];
    assign res  = op == OP_MUL ? prod[SIZE-1:0] :
                  !op[2]       ? prod[2*SIZE-1:SIZE] :
                  !op[1]       ? quot : rmd;
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state  <= S_IDLE;
            busy   <= 1'b0;
            done   <= 1'b0;
            result <= '0;
            cnt    <= '0;
        end else begin
            case (state)
                S_IDLE: if (start) begin
                    op    <= op_in;
                    a     <= abs_a;
                    b     <= abs_b;
                    acc   <= {{SIZE{1'b0}}, funct3[2] ? abs_a : abs_b};
                    rem   <= '0;
                    neg_p <= sa ^ sb;
                    neg_r <= sa;
                    cnt   <= '0;
                    busy  <= 1'b1;
                    state <= S_RUN;
                end
                S_RUN: begin
                    if (op[2]) begin
                        acc <= {acc[2*SIZE-1:SIZE], acc[SIZE-2:0], ge};
                        rem <= ge ? shifted - {1'b0, b} : shifted;
                    end else begin
                        acc <= {msum, acc[SIZE-1:1]};
                    end
                    cnt <= cnt + 1'b1;
                    if (cnt == CW'(SIZE - 1)) state <= S_FIX;
                end
                S_FIX: begin
                    result <= res;
                    busy   <= 1'b0;
                    done   <= 1'b1;
                    state  <= S_DONE;
                end
                default: begin
                    done  <= 1'b0;
                    state <= S_IDLE;
                end
            endcase
        end
    end
endmodule

// File: doc/muldiv_unit.md
MULDIV_UNIT -- requirements
Module: muldiv_unit

Interface
REQ-001 Parameter: SIZE, default 32, operand and result bit-width; only 32 is verified.
REQ-002 Port: clk  input  1  single clock, all state updates on rising edge.
REQ-003 Port: rst_n  input  1  reset, synchronous and active-low.
REQ-004 Port: start  input  1  request pulse, sampled only in IDLE.
REQ-005 Port: funct3  input  3  RV32M operation: 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU.
REQ-006 Port: operand_1  input  SIZE  rs1 value (multiplicand / dividend).
REQ-007 Port: operand_2  input  SIZE  rs2 value (multiplier / divisor).
REQ-008 Port: busy  output  1  high while an operation is in flight; the core stalls PC and register writes while it is high.
REQ-009 Port: done  output  1  one-cycle pulse: result valid and ready for write-back.
REQ-010 Port: result  output  SIZE  registered result; drives operand_2 of the write-back mux2 (select = muldiv instruction).

Function
REQ-011 States SHALL be IDLE, RUN, FIX and DONE.
REQ-012 IDLE: start=1 at edge k SHALL latch funct3, latch operand absolute values/signs per op signedness, clear the iteration counter, and go to RUN.
REQ-013 RUN SHALL perform one iteration per edge: shift-add for multiply, restoring subtract-shift for divide; after 32 iterations (edges k+1..k+32) go to FIX.
REQ-014 FIX (edge k+33) SHALL apply sign correction, select low/high product word or quotient/remainder, register result, and go to DONE.
REQ-015 DONE SHALL assert done for exactly one cycle, then return to IDLE at the next edge.
REQ-016 Latency SHALL be fixed at 33 edges from start acceptance to done=1 for all ops and operand values, special cases included.
REQ-017 busy SHALL be 1 in RUN and FIX, and 0 in IDLE and DONE.
REQ-018 start in RUN, FIX or DONE SHALL be ignored; operands and funct3 are not re-sampled.
REQ-019 result SHALL hold its value from DONE until the FIX of the next accepted operation.
REQ-020 MUL SHALL return product[31:0]; MULH signed×signed [63:32]; MULHSU signed×unsigned [63:32]; MULHU unsigned×unsigned [63:32].
REQ-021 DIV/REM SHALL truncate toward zero; the remainder SHALL take the sign of the dividend.
REQ-022 Divide by zero: DIV/DIVU SHALL return 0xFFFFFFFF; REM/REMU SHALL return operand_1.
REQ-023 Signed overflow (0x80000000 / 0xFFFFFFFF): DIV SHALL return 0x80000000; REM SHALL return 0.
REQ-024 Internal product accumulator SHALL be 2*SIZE bits; the divide remainder register SHALL be SIZE+1 bits.

Reset
REQ-025 rst_n=0 at a rising edge SHALL force IDLE, busy=0, done=0, result=0, counter=0, from any state including mid-RUN.
REQ-026 start coincident with rst_n=0 SHALL be ignored.
REQ-027 The first start after rst_n returns high SHALL be accepted normally.

Structure
REQ-028 funct3 operation encodings and state encodings SHALL live in the shared package muldiv_pkg.
REQ-029 The block SHALL contain no sub-module; the FSM, counter and datapath are inline.
REQ-030 The write-back mux2 instance is outside this block.

Verification
REQ-031 MUL 7 × 0xFFFFFFFD (-3) -> result 0xFFFFFFEB; done exactly 33 edges after start acceptance; busy high for 32+1 cycles.
REQ-032 MULHU 0xFFFFFFFF × 0xFFFFFFFF -> 0xFFFFFFFE; MULH same operands -> 0x00000000; MULHSU 0xFFFFFFFF × 2 -> 0xFFFFFFFF.
REQ-033 DIV 0xFFFFFFF9 (-7) / 2 -> 0xFFFFFFFD; REM -> 0xFFFFFFFF; DIVU 100/7 -> 14; REMU -> 2.
REQ-034 DIVU 5/0 -> 0xFFFFFFFF; REMU 5/0 -> 5; DIV 0x80000000 / 0xFFFFFFFF -> 0x80000000; REM -> 0; all with 33-edge latency.
REQ-035 start pulsed during RUN with different operands -> ignored, original result returned; rst_n=0 at RUN iteration 10 -> next cycle busy=0, done=0, result=0, and a following MUL 3×4 -> 12.
